// File: rtl/zeroriscy_fetch_req_ctrl_if.sv
// Fetch request controller bus: IF-stage control, instruction memory port and fetch FIFO push port.
// master = the controller, slave = the surrounding IF stage / memory / FIFO.
interface zeroriscy_fetch_req_ctrl_if;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic        fifo_ready_i;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_clear_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  modport master (
    input  req_i, branch_i, addr_i, fifo_ready_i,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_clear_o,
    output instr_req_o, instr_addr_o, busy_o
  );

  modport slave (
    output req_i, branch_i, addr_i, fifo_ready_i,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_clear_o,
    input  instr_req_o, instr_addr_o, busy_o
  );
endinterface

// File: rtl/zeroriscy_fetch_req_ctrl.sv
// Fetch request controller: one outstanding word-aligned fetch, responses pushed to the FIFO with zero latency.
// Requests and pushes are combinational; new fetches wait for FIFO room unless a branch redirects.
module zeroriscy_fetch_req_ctrl (
  input  logic                       clk,
  input  logic                       rst_n,
  zeroriscy_fetch_req_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_GNT     = 2'd1,
    WAIT_RVALID  = 2'd2,
    WAIT_ABORTED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] resp_addr_q, resp_addr_d;

  logic        issue;
  logic        instr_req;
  logic        grant;
  logic        fifo_valid;
  logic [31:0] cur_addr;
  logic [31:0] cur_addr_aligned;
  state_e      after_req;

  assign issue            = bus.req_i & (bus.fifo_ready_i | bus.branch_i);
  assign cur_addr         = bus.branch_i ? bus.addr_i : fetch_addr_q;
  assign cur_addr_aligned = {cur_addr[31:2], 2'b00};
  assign grant            = instr_req & bus.instr_gnt_i;
  assign after_req        = bus.instr_gnt_i ? WAIT_RVALID : WAIT_GNT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= 32'h0;
      resp_addr_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      resp_addr_q  <= resp_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    resp_addr_d  = resp_addr_q;

    if (grant) begin
      resp_addr_d  = cur_addr;
      fetch_addr_d = cur_addr_aligned + 32'd4;
    end else if (bus.branch_i) begin
      fetch_addr_d = bus.addr_i;
    end

    case (state_q)
      IDLE: begin
        if (instr_req) state_d = after_req;
      end
      WAIT_GNT: begin
        if (bus.instr_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (bus.instr_rvalid_i) state_d = instr_req ? after_req : IDLE;
        else if (bus.branch_i)  state_d = WAIT_ABORTED;
      end
      WAIT_ABORTED: begin
        // a further branch only moves fetch_addr_q; the stale response is still owed
        if (bus.instr_rvalid_i) state_d = instr_req ? after_req : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_req  = 1'b0;
    fifo_valid = 1'b0;
    case (state_q)
      IDLE:         instr_req = issue;
      WAIT_GNT:     instr_req = 1'b1;
      WAIT_RVALID: begin
        instr_req  = bus.instr_rvalid_i & issue;
        fifo_valid = bus.instr_rvalid_i;
      end
      WAIT_ABORTED: instr_req = bus.instr_rvalid_i & bus.req_i;
      default:      instr_req = 1'b0;
    endcase
  end

  assign bus.instr_req_o  = instr_req;
  assign bus.instr_addr_o = cur_addr_aligned;
  assign bus.fifo_valid_o = fifo_valid;
  assign bus.fifo_addr_o  = resp_addr_q;
  assign bus.fifo_rdata_o = bus.instr_rdata_i;
  assign bus.fifo_clear_o = bus.branch_i;
  assign bus.busy_o       = (state_q != IDLE) | instr_req;

endmodule

// File: tb/tb_zeroriscy_fetch_req_ctrl.sv
// Bench for zeroriscy_fetch_req_ctrl: directed scenarios then random traffic, checked against a
// transaction-level model (pending-grant / outstanding-response / stale-response flags).
module tb_zeroriscy_fetch_req_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zeroriscy_fetch_req_ctrl_if bus ();

  zeroriscy_fetch_req_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  bit          m_wait_gnt, m_out, m_drop;
  logic [31:0] m_next, m_resp;

  bit          e_req, e_grant, e_rv, e_br, e_gnt;
  logic [31:0] e_cur, e_addr;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic model_reset();
    m_wait_gnt = 1'b0;
    m_out      = 1'b0;
    m_drop     = 1'b0;
    m_next     = 32'h0;
    m_resp     = 32'h0;
  endtask

  // Apply one cycle of inputs (at a negedge), then compare outputs against the model.
  task automatic step(input bit req, input bit br, input logic [31:0] a, input bit rdy,
                      input bit gnt, input bit rv, input logic [31:0] rd);
    bit issue;
    bit push;
    bus.req_i          = req;
    bus.branch_i       = br;
    bus.addr_i         = a;
    bus.fifo_ready_i   = rdy;
    bus.instr_gnt_i    = gnt;
    bus.instr_rvalid_i = rv;
    bus.instr_rdata_i  = rd;
    #1;
    issue = req && (rdy || br);
    e_rv  = rv && m_out;
    push  = e_rv && !m_drop;
    if (m_wait_gnt)  e_req = 1'b1;
    else if (m_out)  e_req = e_rv && (m_drop ? req : issue);
    else             e_req = issue;
    e_cur   = br ? a : m_next;
    e_grant = e_req && gnt;
    e_br    = br;
    e_addr  = a;
    e_gnt   = gnt;
    chk_eq("instr_req",  {31'h0, bus.instr_req_o},  {31'h0, e_req});
    chk_eq("instr_addr", bus.instr_addr_o, align(e_cur));
    chk_eq("fifo_valid", {31'h0, bus.fifo_valid_o}, {31'h0, push});
    chk_eq("fifo_clear", {31'h0, bus.fifo_clear_o}, {31'h0, br});
    chk_eq("busy",       {31'h0, bus.busy_o}, {31'h0, (m_wait_gnt || m_out || e_req)});
    if (push) begin
      chk_eq("fifo_addr",  bus.fifo_addr_o,  m_resp);
      chk_eq("fifo_rdata", bus.fifo_rdata_o, rd);
    end
  endtask

  // Advance the model by the transaction outcome of this cycle and move to the next negedge.
  task automatic tick();
    if (e_grant) begin
      m_resp = e_cur;
      m_next = align(e_cur) + 32'd4;
    end else if (e_br) begin
      m_next = e_addr;
    end
    if (e_grant || e_rv)    m_drop = 1'b0;
    else if (m_out && e_br) m_drop = 1'b1;
    if (e_grant)   m_out = 1'b1;
    else if (e_rv) m_out = 1'b0;
    m_wait_gnt = e_req && !e_gnt;
    @(negedge clk);
  endtask

  initial begin
    bus.req_i = 1'b0; bus.branch_i = 1'b0; bus.addr_i = 32'h0; bus.fifo_ready_i = 1'b0;
    bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0; bus.instr_rdata_i = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_eq("rst_instr_req",  {31'h0, bus.instr_req_o}, 32'h0);
    chk_eq("rst_instr_addr", bus.instr_addr_o, 32'h0);
    chk_eq("rst_fifo_valid", {31'h0, bus.fifo_valid_o}, 32'h0);
    chk_eq("rst_busy",       {31'h0, bus.busy_o}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // branch to 0x80, grant, response, back-to-back next request
    step(1, 1, 32'h80, 1, 1, 0, 32'h0);
    chk_eq("t1_addr", bus.instr_addr_o, 32'h80);
    tick();
    step(1, 0, 32'h0, 1, 0, 1, 32'hDEAD_BEEF);
    chk_eq("t1_push_addr",  bus.fifo_addr_o, 32'h80);
    chk_eq("t1_push_data",  bus.fifo_rdata_o, 32'hDEAD_BEEF);
    chk_eq("t1_next_addr",  bus.instr_addr_o, 32'h84);
    chk_eq("t1_next_req",   {31'h0, bus.instr_req_o}, 32'h1);
    tick();
    step(1, 0, 32'h0, 1, 1, 0, 32'h0);
    tick();
    step(0, 0, 32'h0, 1, 0, 1, 32'h1111_2222);
    tick();

    // halfword-offset branch target
    step(1, 1, 32'h102, 1, 1, 0, 32'h0);
    chk_eq("t2_addr", bus.instr_addr_o, 32'h100);
    tick();
    step(1, 0, 32'h0, 1, 1, 1, 32'h3333_4444);
    chk_eq("t2_push_addr", bus.fifo_addr_o, 32'h102);
    chk_eq("t2_next_addr", bus.instr_addr_o, 32'h104);
    tick();
    step(0, 0, 32'h0, 1, 0, 1, 32'h5555_6666);
    chk_eq("t2_push2_addr", bus.fifo_addr_o, 32'h104);
    tick();

    // grant withheld, req dropped, branch retargets
    step(1, 0, 32'h0, 1, 0, 0, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 32'h0, 0, 0, 0, 32'h0);
      chk_eq("t3_hold_req",  {31'h0, bus.instr_req_o}, 32'h1);
      chk_eq("t3_hold_addr", bus.instr_addr_o, 32'h108);
      tick();
    end
    step(0, 1, 32'h200, 0, 0, 0, 32'h0);
    chk_eq("t3_retarget", bus.instr_addr_o, 32'h200);
    tick();
    step(0, 0, 32'h0, 0, 1, 0, 32'h0);
    tick();

    // branch while waiting for a response: stale word discarded
    step(0, 1, 32'h300, 1, 0, 0, 32'h0);
    chk_eq("t4_no_req", {31'h0, bus.instr_req_o}, 32'h0);
    tick();
    step(1, 0, 32'h0, 1, 1, 0, 32'h0);
    chk_eq("t4_still_no_req", {31'h0, bus.instr_req_o}, 32'h0);
    tick();
    step(1, 0, 32'h0, 1, 1, 1, 32'hBAD0_BAD0);
    chk_eq("t4_drop",     {31'h0, bus.fifo_valid_o}, 32'h0);
    chk_eq("t4_req_addr", bus.instr_addr_o, 32'h300);
    tick();
    step(0, 0, 32'h0, 1, 0, 1, 32'h7777_8888);
    chk_eq("t4_push_addr", bus.fifo_addr_o, 32'h300);
    tick();

    // FIFO full holds off fetching; ready rising issues at once
    step(1, 0, 32'h0, 0, 0, 0, 32'h0);
    chk_eq("t5_busy", {31'h0, bus.busy_o}, 32'h0);
    tick();
    step(1, 0, 32'h0, 1, 1, 0, 32'h0);
    chk_eq("t5_req", {31'h0, bus.instr_req_o}, 32'h1);
    tick();
    step(0, 0, 32'h0, 1, 0, 1, 32'h9999_AAAA);
    tick();

    // address wrap
    step(1, 1, 32'hFFFF_FFFC, 1, 1, 0, 32'h0);
    tick();
    step(1, 0, 32'h0, 1, 0, 1, 32'hCCCC_DDDD);
    chk_eq("t6_wrap_addr", bus.instr_addr_o, 32'h0);
    chk_eq("t6_push_addr", bus.fifo_addr_o, 32'hFFFF_FFFC);
    tick();
    step(1, 0, 32'h0, 1, 1, 0, 32'h0);
    tick();

    // reset while a response is outstanding
    bus.req_i = 1'b0; bus.branch_i = 1'b0; bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_eq("t7_rst_req",   {31'h0, bus.instr_req_o}, 32'h0);
    chk_eq("t7_rst_addr",  bus.instr_addr_o, 32'h0);
    chk_eq("t7_rst_busy",  {31'h0, bus.busy_o}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 32'h0, 1, 0, 1, 32'hEEEE_FFFF);
    chk_eq("t7_late_rvalid", {31'h0, bus.fifo_valid_o}, 32'h0);
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           $urandom() & 32'hFFFF_FFFE, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) != 0, m_out && ($urandom_range(0, 1) != 0), $urandom());
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/zeroriscy_fetch_req_ctrl.md
# zeroriscy_fetch_req_ctrl

Fetch request controller: the producer side of the fetch FIFO. It issues word-aligned instruction memory requests over the req/gnt/rvalid interface and pushes returned words, with their addresses, into the FIFO's input port. It sits between the instruction memory port and the fetch FIFO inside the IF stage. It handles branch redirects, including discarding an in-flight response that belongs to the old stream.

## Interface
- No parameters. Address and data are fixed at 32 bits. At most 1 outstanding memory request.
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  1  IF stage wants instructions fetched
- branch_i  in  1  redirect fetch to addr_i this cycle
- addr_i  in  32  branch target; bit 1 may be set, bit 0 is ignored
- fifo_ready_i  in  1  FIFO can accept one more word (FIFO in_ready)
- fifo_valid_o  out  1  push fifo_rdata_o/fifo_addr_o into the FIFO
- fifo_addr_o  out  32  address of pushed word; bit 1 carries the halfword offset for the first word after a branch
- fifo_rdata_o  out  32  pushed instruction word
- fifo_clear_o  out  1  clear FIFO contents
- instr_req_o  out  1  memory request
- instr_addr_o  out  32  request address, bits [1:0] always 00
- instr_gnt_i  in  1  request accepted
- instr_rvalid_i  in  1  response data valid
- instr_rdata_i  in  32  response data
- busy_o  out  1  request pending or response outstanding

## Operation
- Registers:
  - state: IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED
  - fetch_addr_q: next address to fetch, 32 bits, keeps bit 1
  - resp_addr_q: address of the outstanding request, 32 bits
- issue = req_i & (fifo_ready_i | branch_i).
- Request address: cur_addr = branch_i ? addr_i : fetch_addr_q, and instr_addr_o = {cur_addr[31:2], 2'b00}.
- On a grant:
  - resp_addr_q <= cur_addr.
  - fetch_addr_q <= {cur_addr[31:2], 2'b00} + 4, wrapping modulo 2^32.
- On branch_i without a grant: fetch_addr_q <= addr_i.
- fifo_clear_o = branch_i, combinational.
- fifo_rdata_o = instr_rdata_i; fifo_addr_o = resp_addr_q.
- fifo_valid_o = instr_rvalid_i & (state == WAIT_RVALID). Responses are never pushed in any other state.
- State transitions:
  - IDLE: instr_req_o = issue. If issue & gnt -> WAIT_RVALID; if issue & !gnt -> WAIT_GNT; otherwise stay.
  - WAIT_GNT: instr_req_o = 1 regardless of req_i and fifo_ready_i; the request is never withdrawn. A branch retargets instr_addr_o in the same cycle. gnt -> WAIT_RVALID.
  - WAIT_RVALID:
    - If rvalid: push the word. If issue, instr_req_o = 1 in the same cycle, then go to WAIT_RVALID on gnt or WAIT_GNT without gnt. If not issue -> IDLE.
    - If !rvalid & branch_i -> WAIT_ABORTED, with instr_req_o = 0.
  - WAIT_ABORTED: instr_req_o = 0 until rvalid.
    - On rvalid: discard the data (no push). If req_i, issue from fetch_addr_q in the same cycle, then go to WAIT_RVALID or WAIT_GNT. If not req_i -> IDLE.
    - A further branch_i updates fetch_addr_q and the state stays WAIT_ABORTED.
- branch_i together with rvalid in WAIT_RVALID:
  - The word is pushed, but the FIFO's clear has priority, so it is dropped.
  - The new request may issue in the same cycle at addr_i.
- busy_o = (state != IDLE) | instr_req_o.

## Timing
- Reset values:
  - state = IDLE; fetch_addr_q = 0; resp_addr_q = 0.
  - instr_req_o = 0 when req_i = 0, and instr_addr_o = 0.
  - fifo_valid_o = 0; fifo_clear_o = branch_i; busy_o = 0 when req_i = 0.
- Reset asserted mid-transaction: return to IDLE immediately, and drop any later rvalid.
- Latency:
  - The request is combinational from issue.
  - The push is in the same cycle as rvalid, with zero added latency.
  - Back-to-back: with single-cycle gnt and rvalid one cycle after gnt, there is 1 word per cycle.
- Protocol rules:
  - instr_addr_o is stable while instr_req_o = 1 and no gnt, except when branch_i = 1.
  - Never more than 1 granted-but-unanswered request.
  - rvalid outside WAIT_RVALID/WAIT_ABORTED is ignored.
- fifo_valid_o is never asserted when fifo_ready_i was 0 at issue time and no branch occurred.

## Test plan
- Reset, then req_i = 1, branch_i = 1, addr_i = 0x0000_0080, gnt same cycle, rvalid next cycle with rdata 0xDEAD_BEEF -> instr_addr_o = 0x80; push with fifo_addr_o = 0x80. Next request at 0x84 in the same cycle as rvalid.
- Branch to 0x0000_0102 -> instr_addr_o = 0x100; first push has fifo_addr_o = 0x102; second request at 0x104, pushed with fifo_addr_o = 0x104.
- gnt withheld 3 cycles, req_i dropped meanwhile -> instr_req_o stays 1 and the address is unchanged. A branch to 0x200 during the wait retargets instr_addr_o to 0x200.
- Branch to 0x300 while in WAIT_RVALID, rvalid 2 cycles later -> no push and no request until rvalid. In the rvalid cycle, instr_req_o = 1 with addr 0x300; the response is pushed with fifo_addr_o = 0x300.
- fifo_ready_i = 0 with req_i = 1 -> no request and busy_o = 0 once idle. fifo_ready_i rising -> request in the same cycle.
- Fetch at 0xFFFF_FFFC -> next request at 0x0000_0000 (wrap). Reset asserted while in WAIT_RVALID -> outputs take their reset values, and the later rvalid produces no push.
